// File: rtl/rca_nibble_seq_ctrl_if.sv
// Requester-side handshake and operand/result bundle for the nibble-serial adder controller.
// The controller uses the slave modport; the requester uses the master modport.
interface rca_nibble_seq_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
  );
endinterface

// File: rtl/rca_nibble_seq_ctrl.sv
// Wide adder built from one external 4-bit ripple-carry adder, reused one nibble per clock,
// LSB nibble first, with the nibble carry held in a register between cycles.
module rca_nibble_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_nibble_seq_ctrl_if.slave req,
  output logic [3:0]           rca_a,
  output logic [3:0]           rca_b,
  output logic                 rca_cin,
  input  logic [3:0]           rca_s,
  input  logic                 rca_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   s_q, s_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Adder drive kept in its own block so the external rca_s/rca_cout path never looks circular.
  always_comb begin
    rca_a   = 4'd0;
    rca_b   = 4'd0;
    rca_cin = 1'b0;
    if (state_q == RUN) begin
      rca_a   = a_q[4*idx_q +: 4];
      rca_b   = b_q[4*idx_q +: 4];
      rca_cin = carry_q;
    end else begin
      rca_a   = 4'd0;
      rca_b   = 4'd0;
      rca_cin = 1'b0;
    end
  end

  // Next-state and datapath update; s/cout only move on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (req.start) begin
          a_d     = req.a;
          b_d     = req.b;
          carry_d = req.cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[4*idx_q +: 4] = rca_s;
        carry_d             = rca_cout;
        if (idx_q == LAST_IDX) begin
          s_d     = acc_d;
          cout_d  = rca_cout;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign req.busy = busy_q;
  assign req.done = done_q;
  assign req.s    = s_q;
  assign req.cout = cout_q;

endmodule
